// File: rtl/neuron_scheduler.sv
// Time-multiplexes NUM_NEURONS Izhikevich state pairs onto one external RK4 solver,
// one neuron per solver handshake, with per-neuron input current and spike bookkeeping.
module neuron_scheduler #(
  parameter int          NUM_NEURONS = 8,
  parameter logic [15:0] V_INIT      = 16'hDF80,
  parameter logic [15:0] U_INIT      = 16'hF300,
  parameter logic [15:0] C_RESET     = 16'hDF80,
  parameter logic [15:0] D_INC       = 16'h0400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        init,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [15:0] cfg_I,
  input  logic [2:0]  rd_addr,
  output logic [15:0] rd_v,
  output logic [15:0] rd_u,
  output logic        slv_start,
  output logic [15:0] slv_v_in,
  output logic [15:0] slv_u_in,
  output logic [15:0] slv_I_in,
  input  logic [15:0] slv_v_out,
  input  logic [15:0] slv_u_out,
  input  logic        slv_spike,
  input  logic        slv_done,
  output logic        busy,
  output logic        step_done,
  output logic [7:0]  spike_vec,
  output logic [15:0] step_count
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WBACK, S_FINISH} state_t;
  localparam logic [2:0] LAST_IDX = 3'(NUM_NEURONS - 1);

  state_t      r_state;
  logic [2:0]  r_idx;
  logic [15:0] r_v [8];
  logic [15:0] r_u [8];
  logic [15:0] r_I [8];
  logic        r_slv_start;
  logic [15:0] r_op_v, r_op_u, r_op_I;
  logic [15:0] r_cap_v, r_cap_u;
  logic        r_cap_spk;
  logic [7:0]  r_spk;
  logic        r_busy, r_step_done;
  logic [7:0]  r_spike_vec;
  logic [15:0] r_step_count;

  logic [2:0]  w_next_idx;
  logic [7:0]  w_spk_merged;

  assign w_next_idx   = r_idx + 3'd1;
  assign w_spk_merged = r_spk | ({7'd0, r_cap_spk} << r_idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_idx        <= 3'd0;
      for (int i = 0; i < 8; i++) begin
        r_v[i] <= V_INIT;
        r_u[i] <= U_INIT;
        r_I[i] <= 16'd0;
      end
      r_slv_start  <= 1'b0;
      r_op_v       <= 16'd0;
      r_op_u       <= 16'd0;
      r_op_I       <= 16'd0;
      r_cap_v      <= 16'd0;
      r_cap_u      <= 16'd0;
      r_cap_spk    <= 1'b0;
      r_spk        <= 8'd0;
      r_busy       <= 1'b0;
      r_step_done  <= 1'b0;
      r_spike_vec  <= 8'd0;
      r_step_count <= 16'd0;
    end else begin
      r_slv_start <= 1'b0;
      r_step_done <= 1'b0;
      if (cfg_we)
        r_I[cfg_addr] <= cfg_I;

      case (r_state)
        S_IDLE: begin
          if (init) begin
            for (int i = 0; i < 8; i++) begin
              r_v[i] <= V_INIT;
              r_u[i] <= U_INIT;
            end
          end else if (run) begin
            // Operands are latched here so a config write during ISSUE waits for the next sweep.
            r_idx       <= 3'd0;
            r_busy      <= 1'b1;
            r_slv_start <= 1'b1;
            r_op_v      <= r_v[0];
            r_op_u      <= r_u[0];
            r_op_I      <= r_I[0];
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          if (slv_done) begin
            r_cap_v   <= slv_v_out;
            r_cap_u   <= slv_u_out;
            r_cap_spk <= slv_spike;
            r_state   <= S_WBACK;
          end
        end
        S_WBACK: begin
          if (r_cap_spk) begin
            r_v[r_idx] <= C_RESET;
            r_u[r_idx] <= r_cap_u + D_INC;
          end else begin
            r_v[r_idx] <= r_cap_v;
            r_u[r_idx] <= r_cap_u;
          end
          if (r_idx < LAST_IDX) begin
            r_spk       <= w_spk_merged;
            r_idx       <= w_next_idx;
            r_slv_start <= 1'b1;
            r_op_v      <= r_v[w_next_idx];
            r_op_u      <= r_u[w_next_idx];
            r_op_I      <= r_I[w_next_idx];
            r_state     <= S_ISSUE;
          end else begin
            // Sweep results are published together with the step_done pulse.
            r_spike_vec  <= w_spk_merged;
            r_spk        <= 8'd0;
            r_step_count <= r_step_count + 16'd1;
            r_step_done  <= 1'b1;
            r_state      <= S_FINISH;
          end
        end
        S_FINISH: begin
          r_busy  <= 1'b0;
          r_idx   <= 3'd0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_v       = r_v[rd_addr];
  assign rd_u       = r_u[rd_addr];
  assign slv_start  = r_slv_start;
  assign slv_v_in   = r_op_v;
  assign slv_u_in   = r_op_u;
  assign slv_I_in   = r_op_I;
  assign busy       = r_busy;
  assign step_done  = r_step_done;
  assign spike_vec  = r_spike_vec;
  assign step_count = r_step_count;

endmodule

// File: tb/tb_neuron_scheduler.sv
// Scoreboard bench: sweep plans are computed from per-neuron v/u/I arrays and queued;
// a solver model replays the planned responses and a monitor checks every DUT output event.
module tb_neuron_scheduler;
  localparam logic [15:0] V_INIT  = 16'hDF80;
  localparam logic [15:0] U_INIT  = 16'hF300;
  localparam logic [15:0] C_RESET = 16'hDF80;
  localparam logic [15:0] D_INC   = 16'h0400;

  logic        clk = 1'b0;
  logic        reset, run, init, cfg_we;
  logic [2:0]  cfg_addr, rd_addr;
  logic [15:0] cfg_I;
  logic [15:0] rd_v, rd_u;
  logic        slv_start;
  logic [15:0] slv_v_in, slv_u_in, slv_I_in;
  logic [15:0] slv_v_out, slv_u_out;
  logic        slv_spike, slv_done;
  logic        busy, step_done;
  logic [7:0]  spike_vec;
  logic [15:0] step_count;

  neuron_scheduler dut (
    .clk(clk), .reset(reset), .run(run), .init(init),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_I(cfg_I),
    .rd_addr(rd_addr), .rd_v(rd_v), .rd_u(rd_u),
    .slv_start(slv_start), .slv_v_in(slv_v_in), .slv_u_in(slv_u_in), .slv_I_in(slv_I_in),
    .slv_v_out(slv_v_out), .slv_u_out(slv_u_out), .slv_spike(slv_spike), .slv_done(slv_done),
    .busy(busy), .step_done(step_done), .spike_vec(spike_vec), .step_count(step_count)
  );

  always #10 clk = ~clk;

  typedef struct { logic [15:0] v; logic [15:0] u; logic [15:0] i; } op_t;
  typedef struct { logic [15:0] v; logic [15:0] u; logic spk; int lat; } rsp_t;
  typedef struct { logic [7:0] sv; logic [15:0] cnt; int cyc; } swp_t;

  op_t  exp_ops[$];
  rsp_t rsp_q[$];
  swp_t exp_swp[$];

  logic [15:0] m_v [8];
  logic [15:0] m_u [8];
  logic [15:0] m_I [8];
  logic [15:0] m_cnt;

  int checks = 0, errors = 0;
  int cyc = 0, n_starts = 0, n_done = 0;
  int spur_req = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks = checks + 1;
    errors = errors + 1;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  task automatic model_reset(input logic clear_all);
    for (int n = 0; n < 8; n++) begin
      m_v[n] = V_INIT;
      m_u[n] = U_INIT;
      if (clear_all) m_I[n] = 16'd0;
    end
    if (clear_all) m_cnt = 16'd0;
  endtask

  // mode 0 random, 1 v+1.0 no spike L=1, 2 spike on neuron 5 only, 3 random with L=3
  task automatic plan_sweep(input int mode, input int c_run);
    logic [7:0] sv;
    int tot;
    rsp_t r;
    sv = 8'd0;
    tot = 0;
    for (int n = 0; n < 8; n++) begin
      exp_ops.push_back('{m_v[n], m_u[n], m_I[n]});
      r.v   = (mode == 0 || mode == 3) ? 16'($urandom) : m_v[n] + 16'h0080;
      r.u   = (mode == 2) ? 16'hF300 : 16'($urandom);
      r.spk = (mode == 2) ? (n == 5) : (mode == 1) ? 1'b0 : ($urandom_range(0, 3) == 0);
      r.lat = (mode == 3) ? 3 : (mode == 1) ? 1 : int'($urandom_range(1, 4));
      rsp_q.push_back(r);
      if (r.spk) begin
        m_v[n] = C_RESET;
        m_u[n] = r.u + D_INC;
        sv[n]  = 1'b1;
      end else begin
        m_v[n] = r.v;
        m_u[n] = r.u;
      end
      tot = tot + 2 + r.lat;
    end
    m_cnt = m_cnt + 16'd1;
    exp_swp.push_back('{sv, m_cnt, c_run + 1 + tot});
  endtask

  task automatic start_sweep(input int mode);
    plan_sweep(mode, cyc);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (step_done !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t = t + 1;
    end
    run = 1'b0;
    if (t >= 3000) fail("step_done_timeout");
    repeat (2) @(negedge clk);
  endtask

  task automatic check_state();
    for (int n = 0; n < 8; n++) begin
      rd_addr = 3'(n);
      #1;
      check($sformatf("rd_v[%0d]", n), rd_v, m_v[n]);
      check($sformatf("rd_u[%0d]", n), rd_u, m_u[n]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_step_done"}, step_done, 0);
    check({tag, "_spike_vec"}, spike_vec, 0);
    check({tag, "_step_count"}, step_count, 0);
    check({tag, "_slv_start"}, slv_start, 0);
    check({tag, "_ops"}, {slv_v_in, slv_u_in}, 0);
    check({tag, "_op_I"}, slv_I_in, 0);
  endtask

  // Solver model: replays planned responses after the planned latency.
  initial begin : solver
    rsp_t r;
    int spur_seen;
    spur_seen = 0;
    slv_done = 1'b0; slv_spike = 1'b0; slv_v_out = 16'd0; slv_u_out = 16'd0;
    forever begin
      @(negedge clk);
      if (slv_start === 1'b1) begin
        if (rsp_q.size() > 0) r = rsp_q.pop_front();
        else r = '{16'd0, 16'd0, 1'b0, 1};
        repeat (r.lat) @(posedge clk);
        #1;
        slv_v_out = r.v; slv_u_out = r.u; slv_spike = r.spk; slv_done = 1'b1;
        @(posedge clk);
        #1;
        slv_done = 1'b0; slv_spike = 1'b0;
      end else if (spur_seen != spur_req) begin
        spur_seen = spur_seen + 1;
        slv_v_out = 16'h1234; slv_u_out = 16'h5678; slv_spike = 1'b1; slv_done = 1'b1;
        @(posedge clk);
        #1;
        slv_done = 1'b0; slv_spike = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a start pulse or step_done.
  logic prev_start = 1'b0;
  logic pend = 1'b0;
  swp_t pend_s;
  always @(negedge clk) begin
    op_t o;
    swp_t s;
    if (pend) begin
      check("spike_vec", spike_vec, pend_s.sv);
      check("step_count", step_count, pend_s.cnt);
      check("busy_after_done", busy, 0);
      pend = 1'b0;
    end
    if (slv_start === 1'b1) begin
      n_starts = n_starts + 1;
      check("start_back_to_back", prev_start, 0);
      if (exp_ops.size() == 0) fail("unexpected_slv_start");
      else begin
        o = exp_ops.pop_front();
        check("slv_v_in", slv_v_in, o.v);
        check("slv_u_in", slv_u_in, o.u);
        check("slv_I_in", slv_I_in, o.i);
      end
    end
    if (step_done === 1'b1) begin
      n_done = n_done + 1;
      check("busy_at_done", busy, 1);
      if (exp_swp.size() == 0) fail("unexpected_step_done");
      else begin
        s = exp_swp.pop_front();
        check("sweep_latency", cyc, s.cyc);
        pend_s = s;
        pend = 1'b1;
      end
    end
    prev_start = slv_start;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int base, t, d0;
    reset = 1'b1; run = 1'b0; init = 1'b0; cfg_we = 1'b0;
    cfg_addr = 3'd0; cfg_I = 16'd0; rd_addr = 3'd0;
    model_reset(1'b1);
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    check_state();
    reset = 1'b0;
    @(negedge clk);

    // v+1.0 per neuron, no spikes
    start_sweep(1);
    wait_done();
    check("starts_per_sweep", n_starts, 8);
    check("done_count", n_done, 1);
    rd_addr = 3'd3; #1;
    check("rd_v3_plus_one", rd_v, 16'hE000);
    check_state();

    // spike on neuron 5 only
    start_sweep(2);
    wait_done();
    rd_addr = 3'd5; #1;
    check("rd_v5_reset", rd_v, 16'hDF80);
    check("rd_u5_inc", rd_u, 16'hF700);
    check("spike_vec_n5", spike_vec, 8'h20);
    check_state();

    // per-neuron input current
    cfg_we = 1'b1; cfg_addr = 3'd2; cfg_I = 16'h0500;
    @(negedge clk);
    cfg_we = 1'b0;
    m_I[2] = 16'h0500;
    start_sweep(0);
    wait_done();

    // write during neuron 2's ISSUE applies only from the next sweep
    base = n_starts;
    start_sweep(0);
    t = 0;
    while (n_starts < base + 3 && t < 500) begin @(negedge clk); t = t + 1; end
    if (t >= 500) fail("issue2_timeout");
    cfg_we = 1'b1; cfg_addr = 3'd2; cfg_I = 16'h0123;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    m_I[2] = 16'h0123;
    wait_done();
    start_sweep(0);
    wait_done();
    check_state();

    // run held and re-pulsed, init pulsed, all while busy
    d0 = n_done;
    plan_sweep(0, cyc);
    run = 1'b1;
    repeat (10) @(negedge clk);
    run = 1'b0; init = 1'b1;
    @(negedge clk);
    init = 1'b0; run = 1'b1;
    wait_done();
    repeat (20) @(negedge clk);
    check("held_run_one_sweep", n_done, d0 + 1);
    check("held_run_no_extra_start", exp_ops.size(), 0);
    check_state();

    // random sweeps with config changes
    for (int k = 0; k < 3; k++) begin
      cfg_we = 1'b1; cfg_addr = 3'($urandom_range(0, 7)); cfg_I = 16'($urandom);
      m_I[cfg_addr] = cfg_I;
      @(negedge clk);
      cfg_we = 1'b0;
      start_sweep(0);
      wait_done();
      check_state();
    end

    // init with run together: reload only
    base = n_starts;
    init = 1'b1; run = 1'b1;
    @(negedge clk);
    init = 1'b0; run = 1'b0;
    model_reset(1'b0);
    repeat (4) @(negedge clk);
    check("init_run_no_start", n_starts, base);
    check("init_run_not_busy", busy, 0);
    check_state();

    // stray solver completion while idle
    spur_req = spur_req + 1;
    repeat (5) @(negedge clk);
    check("stray_done_not_busy", busy, 0);
    check_state();

    // reset during WAIT of neuron 4
    d0 = n_done;
    base = n_starts;
    start_sweep(3);
    t = 0;
    while (n_starts < base + 5 && t < 500) begin @(negedge clk); t = t + 1; end
    if (t >= 500) fail("issue4_timeout");
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    exp_ops.delete(); exp_swp.delete(); rsp_q.delete();
    model_reset(1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("late_done_no_sweep", n_done, d0);
    check("late_done_count", step_count, 0);
    check_state();
    base = n_starts;
    start_sweep(0);
    wait_done();
    check("restart_starts", n_starts, base + 8);
    check_state();

    // step_count wrap
    force dut.r_step_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_step_count;
    m_cnt = 16'hFFFF;
    @(negedge clk);
    start_sweep(0);
    wait_done();
    check("wrap_count", step_count, 16'h0000);

    check("leftover_ops", exp_ops.size(), 0);
    check("leftover_sweeps", exp_swp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/neuron_scheduler.md
NEURON_SCHEDULER -- requirements
Module: neuron_scheduler

Interface
REQ-001 Parameter NUM_NEURONS, default 8: neurons time-multiplexed onto one RK4 solver; fixed index width 3 bits.
REQ-002 Parameter V_INIT, default 16'hDF80 (-65.0 in 9.7): power-up/init membrane potential.
REQ-003 Parameter U_INIT, default 16'hF300 (-26.0): power-up/init recovery variable.
REQ-004 Parameter C_RESET, default 16'hDF80 (-65.0): post-spike v value.
REQ-005 Parameter D_INC, default 16'h0400 (8.0): post-spike u increment.
REQ-006 Clock and reset: reset reset, asynchronous, active-high; clock clk.
REQ-007 clk  in  1  clock.
REQ-008 reset  in  1  asynchronous active-high reset.
REQ-009 run  in  1  request one timestep sweep over all neurons.
REQ-010 init  in  1  reload all v/u to V_INIT/U_INIT.
REQ-011 cfg_we  in  1  write strobe for per-neuron input current.
REQ-012 cfg_addr  in  3  neuron index for cfg_we.
REQ-013 cfg_I  in  16  input current, 9.7 two's complement.
REQ-014 rd_addr  in  3  neuron index for state readback.
REQ-015 rd_v, rd_u  out  16 each  combinational readback of stored v/u at rd_addr.
REQ-016 slv_start  out  1  one-cycle start pulse to solver.
REQ-017 slv_v_in, slv_u_in, slv_I_in  out  16 each  operands for current neuron; held stable from pulse until slv_done.
REQ-018 slv_v_out, slv_u_out  in  16 each  solver results.
REQ-019 slv_spike, slv_done  in  1 each  solver spike flag and completion pulse.
REQ-020 busy  out  1  high from sweep acceptance until step_done cycle inclusive.
REQ-021 step_done  out  1  one-cycle pulse at sweep completion.
REQ-022 spike_vec  out  8  bit n = neuron n spiked in last completed sweep.
REQ-023 step_count  out  16  completed sweeps, wraps 16'hFFFF -> 0.

Function
REQ-024 FSM states IDLE, ISSUE, WAIT, WBACK, FINISH; encoding free.
REQ-025 IDLE: run=1 -> ISSUE with idx=0, busy=1; init=1 (run=0) -> all v/u reloaded in one cycle, stay IDLE; run and init together -> init applied first cycle, run ignored.
REQ-026 ISSUE: slv_start=1 for exactly one cycle with operands of neuron idx -> WAIT.
REQ-027 WAIT: hold until slv_done=1; capture slv_v_out, slv_u_out, slv_spike that cycle -> WBACK.
REQ-028 WBACK: spike=0 -> store v=slv_v_out, u=slv_u_out; spike=1 -> v=C_RESET, u=slv_u_out+D_INC (16-bit wrap); set sweep-local spike bit idx; idx<NUM_NEURONS-1 -> idx+1, ISSUE; else -> FINISH.
REQ-029 FINISH: spike_vec <= sweep-local bits, step_count+1, step_done=1, sweep-local bits cleared -> IDLE; busy drops next cycle.
REQ-030 slv_start never asserted outside ISSUE; minimum one WBACK cycle between consecutive pulses.
REQ-031 run, init while busy ignored (not queued).
REQ-032 cfg_we accepted any state; write in same cycle as ISSUE for that index takes effect next sweep (operand registered at ISSUE).
REQ-033 slv_done outside WAIT ignored.
REQ-034 spike_vec and step_count change only in FINISH.
REQ-035 Sweep latency = NUM_NEURONS*(2+L)+1 cycles from run accept to step_done, L = solver cycles from start to done.

Reset
REQ-036 reset asserted: state IDLE, idx 0, all v=V_INIT, u=U_INIT, all I=0, slv_start=0, operand outputs 0, busy=0, step_done=0, spike_vec=0, step_count=0.
REQ-037 reset mid-sweep aborts immediately; subsequent slv_done ignored; no partial spike_vec update.

Verification
REQ-038 After reset, run pulse, solver model returning v+1.0, no spike: 8 slv_start pulses idx 0..7, step_done once, step_count=1, spike_vec=0, rd_v(3)=16'hDF80+16'h0080.
REQ-039 Model asserts slv_spike for neuron 5 only, u_out=16'hF300: rd_v(5)=16'hDF80, rd_u(5)=16'hF700, spike_vec=8'h20.
REQ-040 cfg_we addr 2, cfg_I=16'h0500, then run: slv_I_in=16'h0500 during neuron 2 issue, 0 for others.
REQ-041 run held high through sweep and re-pulsed while busy: exactly one sweep, step_count increments by 1 only.
REQ-042 reset asserted during WAIT of neuron 4: all outputs at reset values next cycle; late slv_done produces no writeback; next run restarts at idx 0.
REQ-043 step_count preloaded by 65535 sweeps: next step_done -> step_count=0.
